// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for the pipelined adder/subtractor: an issue side
// (in_*) and a retire side (out_*).
`timescale 1ns/1ps

interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  // Producer of operations and consumer of results.
  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );

  // The arithmetic block itself.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES
// ripple segments, one segment per clock, carries registered between segments.
`timescale 1ns/1ps

module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic                clk,
  input logic                rst,
  pipelined_addsub_if.slave  bus
);

  localparam int SEG = WIDTH / STAGES;

  logic             stall;
  logic             advance;
  logic [WIDTH-1:0] b_prep;
  logic             c0;

  // The whole pipe freezes (bubbles included) while the head result waits.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign advance      = ~stall;
  assign bus.in_ready = ~stall;

  // Subtract is A + ~B + 1; a borrow-in removes that +1.
  assign b_prep = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0     = bus.in_sub ? ~bus.in_cin : bus.in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // IW: operand bits not yet summed when entering stage k.
    // OW: result bits finished once stage k has run.
    localparam int IW = WIDTH - k * SEG;
    localparam int OW = (k + 1) * SEG;

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [SEG:0]  seg_sum;
    logic [OW-1:0] s_next;
    logic [OW-1:0] s_q;
    logic          c_q;
    logic          v_q;

    if (k == 0) begin : g_head
      assign a_in   = bus.in_a;
      assign b_in   = b_prep;
      assign c_in   = c0;
      assign v_in   = bus.in_valid;
      assign s_next = seg_sum[SEG-1:0];
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_carry.a_q;
      assign b_in   = g_stage[k-1].g_carry.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, c_in};

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, giving a true shift.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= seg_sum[SEG];
        s_q <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_carry
      // Unsummed upper slices ride along to the next stage.
      logic [IW-SEG-1:0] a_q;
      logic [IW-SEG-1:0] b_q;

      // NOTE: these are pure data; the stage valid bit qualifies them, so
      // they carry no reset and may load freely, even on bubbles.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_in[IW-1:SEG];
          b_q <= b_in[IW-1:SEG];
        end
      end
    end else begin : g_tail
      // The last segment holds both operand MSBs, so overflow is settled here.
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (a_in[SEG-1] == b_in[SEG-1]) & (seg_sum[SEG-1] != a_in[SEG-1]);
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.out_sum   = g_stage[STAGES-1].s_q;
  assign bus.out_cout  = g_stage[STAGES-1].c_q;
  assign bus.out_ovf   = g_stage[STAGES-1].g_tail.ovf_q;
  assign bus.out_neg   = g_stage[STAGES-1].s_q[WIDTH-1];
  // Qualified by valid so the cleared post-reset sum does not report zero.
  assign bus.out_zero  = g_stage[STAGES-1].v_q & ~|g_stage[STAGES-1].s_q;

endmodule
